// File: rtl/dmem_responder_if.sv
// Load/store handshake between the datapath (master) and the data memory (slave).
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output req, we, addr, writedata,
    input  readdata, ready, busy, err
  );

  modport slave (
    input  req, we, addr, writedata,
    output readdata, ready, busy, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-array data memory with a LATENCY wait-state req/ready handshake.
// Optional `DMEM_MISALIGN_TRAP_EN: misaligned accesses are suppressed and flagged on err.
//   state  | meaning
//   IDLE   | waiting for req; latches the request
//   WAIT   | counting down wait states
//   DONE   | ready pulse; access performed on the edge entering this state
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  logic [31:0]   mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          err_q, err_d;

  logic          go;
  logic          acc_we;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_wd;
  logic [AW-1:0] idx;
  logic          acc_ok;
  logic          unused_bits;

  assign unused_bits = ^{bus.addr[31:AW+2], acc_addr[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    readdata_d = readdata_q;
    err_d      = 1'b0;
    go         = 1'b0;
    acc_we     = we_q;
    acc_addr   = addr_q;
    acc_wd     = wd_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d   = bus.we;
          addr_d = bus.addr[AW+1:0];
          wd_d   = bus.writedata;
          if (LATENCY == 0) begin
            // zero latency: access straight from the port on the accept edge
            state_d  = S_DONE;
            go       = 1'b1;
            acc_we   = bus.we;
            acc_addr = bus.addr[AW+1:0];
            acc_wd   = bus.writedata;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          go      = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    idx = acc_addr[AW+1:2];
`ifdef DMEM_MISALIGN_TRAP_EN
    acc_ok = (acc_addr[1:0] == 2'b00);
    err_d  = go & ~acc_ok;
`else
    acc_ok = 1'b1;
`endif
    if (go) begin
      if (!acc_ok)     readdata_d = 32'd0;
      else if (!acc_we) readdata_d = mem[idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wd_q       <= 32'd0;
      readdata_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      readdata_q <= readdata_d;
      err_q      <= err_d;
    end
  end

  // array is not reset; a held reset must still block a commit
  always_ff @(posedge clk) begin
    if (go && acc_we && acc_ok && !reset) mem[idx] <= acc_wd;
  end

  assign bus.readdata = readdata_q;
  assign bus.ready    = (state_q == S_DONE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.err      = err_q;
endmodule
